// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-block game sequencer: phase encodings,
// board geometry, piece type codes, LFSR seed and small helper functions.
package tetris_pkg;

  // Phase encodings presented to the downstream clear_redraw block
  typedef enum logic [2:0] {
    ST_GEN   = 3'b000,
    ST_MOVE  = 3'b001,
    ST_LAND  = 3'b010,
    ST_CLEAR = 3'b011,
    ST_OVER  = 3'b100
  } state_t;

  // Board geometry: 8 rows of 4 cells, cell (r,c) lives at bit 4r+c
  localparam int BOARD_W = 32;
  localparam int ROW_W   = 4;
  localparam int ROWS    = 8;

  // Piece type codes
  localparam logic [1:0] PIECE_SINGLE = 2'd0;
  localparam logic [1:0] PIECE_HPAIR  = 2'd1;
  localparam logic [1:0] PIECE_VPAIR  = 2'd2;
  localparam logic [1:0] PIECE_SQUARE = 2'd3;

  // Random piece generator seed
  localparam logic [3:0] LFSR_SEED = 4'b1001;

  // One step of the x^4+x^3+1 Fibonacci LFSR
  function automatic logic [3:0] lfsr_next(input logic [3:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction

  // Number of completely filled rows on a board
  function automatic logic [3:0] count_full_rows(input logic [BOARD_W-1:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int r = 0; r < ROWS; r++) begin
      if (b[r*ROW_W +: ROW_W] == 4'hF) begin
        n = n + 4'd1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/piece_mask.sv
// Combinational footprint of a piece: cell mask on the board for a given
// anchor (bottom-left cell) and a legal flag that is set when every cell is
// inside the board and none overlaps an occupied cell.
module piece_mask
  import tetris_pkg::*;
(
  input  logic [1:0]         piece,
  input  logic [2:0]         row,
  input  logic [1:0]         col,
  input  logic [BOARD_W-1:0] board,
  output logic [BOARD_W-1:0] mask,
  output logic               legal
);

  logic [BOARD_W-1:0] base_s;
  logic               in_bounds_s;

  // Build the footprint; out-of-bounds shapes may wrap but are never legal
  always_comb begin
    base_s      = 32'd1 << {row, col};
    mask        = base_s;
    in_bounds_s = 1'b1;
    case (piece)
      PIECE_SINGLE: begin
        mask        = base_s;
        in_bounds_s = 1'b1;
      end
      PIECE_HPAIR: begin
        mask        = base_s | (base_s << 5'd1);
        in_bounds_s = (col != 2'd3);
      end
      PIECE_VPAIR: begin
        mask        = base_s | (base_s << 5'd4);
        in_bounds_s = (row != 3'd7);
      end
      PIECE_SQUARE: begin
        mask        = base_s | (base_s << 5'd1) | (base_s << 5'd4) | (base_s << 5'd5);
        in_bounds_s = (col != 2'd3) && (row != 3'd7);
      end
      default: begin
        mask        = base_s;
        in_bounds_s = 1'b0;
      end
    endcase
    legal = in_bounds_s && ((mask & board) == 32'd0);
  end

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: spawns pseudo-random pieces, applies lateral moves and
// gravity, merges landed pieces into the board and hands the board to the
// external clear_redraw block, capturing its cleared result.
// Optional feature macro: GAME_SEQ_SCORE_EN builds the full-row score counter;
// without it score is tied to zero.
module game_sequencer
  import tetris_pkg::*;
#(
  parameter int CLR_LAT = 1
)
(
  input  logic               clka,
  input  logic               restart,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               tick,
  input  logic [BOARD_W-1:0] clr_board,
  input  logic               clr_error,
  output logic [2:0]         state,
  output logic [BOARD_W-1:0] board_out,
  output logic [1:0]         curr_piece,
  output logic [2:0]         pos_row,
  output logic [1:0]         pos_col,
  output logic               game_over,
  output logic               error,
  output logic [7:0]         score
);

  // Final cycle index of the CLEAR phase (CLEAR lasts CLR_LAT+1 cycles)
  localparam logic [7:0] CLR_LAST = 8'(CLR_LAT);

  state_t             state_r;
  logic [BOARD_W-1:0] board_r;
  logic [1:0]         piece_r;
  logic [2:0]         row_r;
  logic [1:0]         col_r;
  logic               over_r;
  logic               error_r;
  logic [3:0]         lfsr_r;
  logic [7:0]         clr_cnt_r;

  logic [1:0]         cur_piece_s;
  logic [2:0]         cur_row_s;
  logic [1:0]         cur_col_s;
  logic [BOARD_W-1:0] cur_mask_s;
  logic               cur_legal_s;
  logic               left_legal_s;
  logic               right_legal_s;
  logic               down_legal_s;
  logic               left_ok_s;
  logic               right_ok_s;
  logic               down_ok_s;
  logic [1:0]         lat_col_s;
  logic [BOARD_W-1:0] left_mask_unused_s;
  logic [BOARD_W-1:0] right_mask_unused_s;
  logic [BOARD_W-1:0] down_mask_unused_s;

  // In GEN the current candidate is the spawn position, otherwise the active piece
  always_comb begin
    if (state_r == ST_GEN) begin
      cur_piece_s = lfsr_r[1:0];
      cur_row_s   = lfsr_r[1] ? 3'd6 : 3'd7;
      cur_col_s   = 2'd1;
    end else begin
      cur_piece_s = piece_r;
      cur_row_s   = row_r;
      cur_col_s   = col_r;
    end
  end

  piece_mask u_cur (
    .piece (cur_piece_s),
    .row   (cur_row_s),
    .col   (cur_col_s),
    .board (board_r),
    .mask  (cur_mask_s),
    .legal (cur_legal_s)
  );

  piece_mask u_left (
    .piece (piece_r),
    .row   (row_r),
    .col   (col_r - 2'd1),
    .board (board_r),
    .mask  (left_mask_unused_s),
    .legal (left_legal_s)
  );

  piece_mask u_right (
    .piece (piece_r),
    .row   (row_r),
    .col   (col_r + 2'd1),
    .board (board_r),
    .mask  (right_mask_unused_s),
    .legal (right_legal_s)
  );

  // The drop candidate sits one row below the post-lateral position
  piece_mask u_down (
    .piece (piece_r),
    .row   (row_r - 3'd1),
    .col   (lat_col_s),
    .board (board_r),
    .mask  (down_mask_unused_s),
    .legal (down_legal_s)
  );

  // Column arithmetic wraps, so edge columns are excluded explicitly
  always_comb begin
    left_ok_s  = left_legal_s && (col_r != 2'd0);
    right_ok_s = right_legal_s && (col_r != 2'd3);
    down_ok_s  = down_legal_s && (row_r != 3'd0);
  end

  // Lateral move: exactly one button pressed and the target is legal
  always_comb begin
    if (btn_left && !btn_right && left_ok_s) begin
      lat_col_s = col_r - 2'd1;
    end else if (btn_right && !btn_left && right_ok_s) begin
      lat_col_s = col_r + 2'd1;
    end else begin
      lat_col_s = col_r;
    end
  end

  // Main phase sequencer with LFSR, board, piece and status registers
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state_r   <= ST_GEN;
      board_r   <= 32'd0;
      piece_r   <= PIECE_SINGLE;
      row_r     <= 3'd7;
      col_r     <= 2'd1;
      over_r    <= 1'b0;
      error_r   <= 1'b0;
      lfsr_r    <= LFSR_SEED;
      clr_cnt_r <= 8'd0;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
      case (state_r)
        ST_GEN: begin
          piece_r <= cur_piece_s;
          row_r   <= cur_row_s;
          col_r   <= cur_col_s;
          if (cur_legal_s) begin
            state_r <= ST_MOVE;
          end else begin
            state_r <= ST_OVER;
            over_r  <= 1'b1;
          end
        end
        ST_MOVE: begin
          col_r <= lat_col_s;
          if (tick) begin
            if (down_ok_s) begin
              row_r <= row_r - 3'd1;
            end else begin
              state_r <= ST_LAND;
            end
          end else begin
            state_r <= ST_MOVE;
          end
        end
        ST_LAND: begin
          board_r   <= board_r | cur_mask_s;
          clr_cnt_r <= 8'd0;
          state_r   <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (clr_cnt_r == CLR_LAST) begin
            if (clr_error) begin
              error_r <= 1'b1;
            end else begin
              board_r <= clr_board;
            end
            state_r <= ST_GEN;
          end else begin
            clr_cnt_r <= clr_cnt_r + 8'd1;
          end
        end
        ST_OVER: begin
          over_r  <= 1'b1;
          state_r <= ST_OVER;
        end
        default: begin
          state_r <= ST_GEN;
        end
      endcase
    end
  end

`ifdef GAME_SEQ_SCORE_EN
  logic [3:0] full_rows_s;
  logic [8:0] score_sum_s;
  logic [7:0] score_r;

  // Rows completed by the piece being merged this LAND cycle
  always_comb begin
    full_rows_s = count_full_rows(board_r | cur_mask_s);
    score_sum_s = {1'b0, score_r} + {5'd0, full_rows_s};
  end

  // Saturating score, updated as the merged board enters CLEAR
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      score_r <= 8'd0;
    end else if (state_r == ST_LAND) begin
      score_r <= score_sum_s[8] ? 8'hFF : score_sum_s[7:0];
    end else begin
      score_r <= score_r;
    end
  end

  assign score = score_r;
`else
  assign score = 8'd0;
`endif

  assign state      = state_r;
  assign board_out  = board_r;
  assign curr_piece = piece_r;
  assign pos_row    = row_r;
  assign pos_col    = col_r;
  assign game_over  = over_r;
  assign error      = error_r;

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter CLR_LAT, default 1, meaning cycles the downstream clear_redraw needs from state=CLEAR to a valid clr_board.
REQ-002 SHALL have port clka, input, 1, the single clock.
REQ-003 SHALL have port restart, input, 1, reset (asynchronous, active-high).
REQ-004 SHALL have port btn_left, input, 1, move-left request, sampled each cycle.
REQ-005 SHALL have port btn_right, input, 1, move-right request, sampled each cycle.
REQ-006 SHALL have port tick, input, 1, gravity strobe, one cycle wide.
REQ-007 SHALL have port clr_board, input, 32, cleared board returned by clear_redraw.
REQ-008 SHALL have port clr_error, input, 1, clear_redraw error flag.
REQ-009 SHALL have port state, output, 3, phase driven to clear_redraw: GEN=000, MOVE=001, LAND=010, CLEAR=011, OVER=100.
REQ-010 SHALL have port board_out, output, 32, settled board (feeds clear_redraw board_in).
REQ-011 SHALL have port curr_piece, output, 2, active piece type.
REQ-012 SHALL have ports pos_row (3) and pos_col (2), outputs, active piece anchor (bottom-left cell).
REQ-013 SHALL have outputs game_over (1), error (1), and score (8).

Function
REQ-014 Board SHALL be 8 rows x 4 columns; cell (r,c) is bit 4r+c; row 0 is bottom; a full row is nibble 0xF.
REQ-015 Pieces SHALL be: 0 = single cell (r,c); 1 = horizontal pair (r,c),(r,c+1); 2 = vertical pair (r,c),(r+1,c); 3 = 2x2 square.
REQ-016 A position SHALL be legal when every cell lies inside the board and no cell overlaps board_out.
REQ-017 A 4-bit LFSR (taps x^4+x^3+1, seed 4'b1001) SHALL advance every cycle outside reset.
REQ-018 GEN SHALL last one cycle:
- load curr_piece = lfsr[1:0], pos_col = 1, pos_row = 7 (pieces 0,1) or 6 (pieces 2,3).
- go to OVER if the spawn position is illegal, else to MOVE.
REQ-019 MOVE lateral motion, each cycle:
- btn_left only: pos_col-1 if legal.
- btn_right only: pos_col+1 if legal.
- both or neither: no move.
REQ-020 In MOVE with tick=1, the drop check SHALL use the post-lateral position:
- pos_row-1 if pos_row>0 and legal.
- otherwise go to LAND with the position held.
REQ-021 LAND SHALL last one cycle: board_out <= board_out | piece mask; next state CLEAR.
REQ-022 CLEAR SHALL hold state=011 for exactly CLR_LAT+1 cycles, then on the final cycle:
- if clr_error=0: capture board_out <= clr_board.
- if clr_error=1: keep board_out unchanged and set error (sticky until reset).
- go to GEN.
REQ-023 On entry to CLEAR, score SHALL add the count of 0xF nibbles in board_out, saturating at 255.
REQ-024 OVER SHALL be terminal: game_over=1, board_out frozen, buttons and tick ignored until restart.
REQ-025 curr_piece, pos_row and pos_col SHALL change only in GEN or MOVE.

Reset
REQ-026 restart=1 SHALL immediately force: state=GEN, board_out=0, curr_piece=0, pos_row=7, pos_col=1, score=0, game_over=0, error=0, lfsr=4'b1001.
REQ-027 Reset asserted in any state, including mid-CLEAR, SHALL abort the operation without capturing clr_board.

Configuration
REQ-028 With macro GAME_SEQ_SCORE_EN defined, the score counter of REQ-023 SHALL be built; without it, score SHALL be tied to 0 and no row-count logic is synthesised.

Structure
REQ-029 Shared package tetris_pkg SHALL hold:
- the state encodings of REQ-009.
- BOARD_W=32, ROW_W=4, ROWS=8.
- piece type constants.
- LFSR seed.
REQ-030 Combinational sub-module piece_mask SHALL map (piece, row, col, board) to a 32-bit mask plus a legal flag; game_sequencer SHALL instantiate it for current, left, right and down candidates.

Verification
REQ-031 Reset: restart=1 mid-MOVE -> state=000, board_out=0x00000000, score=0, game_over=0, error=0.
REQ-032 Drop: force piece 3 on an empty board, tick every cycle -> pos_row falls 6 to 0 in 6 ticks; after LAND, board_out=0x00000066; state goes to 011.
REQ-033 Lateral: piece 1 at col 1:
- btn_right -> col 2.
- btn_right again -> stays 2.
- btn_left+btn_right together -> stays 2.
- btn_left three times -> col 0.
REQ-034 Clear: land square at col 0, then square at col 2 (board 0x000000FF), stub clr_board=0 with CLR_LAT=1 -> state=011 for 2 cycles, board_out=0, score=2.
REQ-035 Error: clr_error=1 on the capture cycle -> board_out unchanged, error=1, persists through later GEN/MOVE until restart.
REQ-036 Game over: stack pieces until a spawn overlaps -> state=100, game_over=1, board_out frozen under tick and buttons; restart recovers to GEN.
